// File: rtl/score_accumulator_bcd_pkg.sv
// rtl/score_accumulator_bcd_pkg.sv - shared types and constants for the BCD score accumulator
package score_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    COMMIT
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE = 4'd9;

  // Packed BCD value with the low n digits set to nine (n at most 8)
  function automatic logic [31:0] all_nines(input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) r[4*i +: 4] = BCD_NINE;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_accumulator_bcd_digit_add.sv
// rtl/score_accumulator_bcd_digit_add.sv - single-digit combinational BCD adder
module bcd_digit_add
  import score_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t sum,
  output logic       cout
);

  logic [4:0] raw;

  // Binary add, then fold anything past nine back into a decimal digit plus carry
  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (raw > 5'd9) begin
      sum  = 4'(raw - 5'd10);
      cout = 1'b1;
    end else begin
      sum  = raw[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/score_accumulator_bcd.sv
// rtl/score_accumulator_bcd.sv - event-driven saturating BCD score accumulator with high score
module score_accumulator_bcd
  import score_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int NUM_SRC = 4,
  parameter int PEND_W  = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  clear,
  input  logic [NUM_SRC-1:0]    event_pulse,
  input  logic [8*NUM_SRC-1:0]  src_points,
  input  logic                  game_over,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   high_score_bcd,
  output logic                  busy,
  output logic                  dropped
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [31:0] NINES = all_nines(DIGITS);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t state, state_next;

  bcd_digit_t [DIGITS-1:0] score, high, work, addend;
  logic                    carry;
  logic [IDX_W-1:0]        idx;

  logic [PEND_W-1:0]               cnt [NUM_SRC];
  logic [NUM_SRC-1:0][PEND_W-1:0]  cnt_next;
  logic [NUM_SRC-1:0]              pend_nz, grant, drop_vec;
  logic [SRC_W-1:0]                sel;
  logic                            any_pend;

  logic       hs_req, hs_serve;
  logic       busy_q, dropped_q;
  bcd_digit_t dsum;
  logic       dcout;
  logic [7:0] sel_pts;
  bcd_digit_t pts_lo, pts_hi;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pend
    logic inc;
    // A pulse coinciding with clear belongs to the old game and is discarded
    assign inc          = event_pulse[gi] & ~clear;
    assign pend_nz[gi]  = (cnt[gi] != '0);
    assign drop_vec[gi] = inc & ~grant[gi] & (cnt[gi] == PEND_MAX);
    assign cnt_next[gi] = clear                                         ? '0 :
                          (inc && !grant[gi] && cnt[gi] != PEND_MAX)   ? cnt[gi] + PEND_W'(1) :
                          (grant[gi] && !inc)                          ? cnt[gi] - PEND_W'(1) :
                                                                         cnt[gi];
    // Per-source pending award count
    always_ff @(posedge Clk) begin
      if (Reset) cnt[gi] <= '0;
      else       cnt[gi] <= cnt_next[gi];
    end
  end

  assign any_pend = |pend_nz;

  // Lowest-index source with pending awards wins the grant
  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pend_nz[i]) sel = SRC_W'(i);
    end
  end

  // Points of the selected source, each nibble clamped to a legal BCD digit
  always_comb begin
    sel_pts = src_points[8*int'(sel) +: 8];
    pts_lo  = (sel_pts[3:0] > BCD_NINE) ? BCD_NINE : sel_pts[3:0];
    pts_hi  = (sel_pts[7:4] > BCD_NINE) ? BCD_NINE : sel_pts[7:4];
  end

  // Next state and grant; clear always forces the FSM back to IDLE
  always_comb begin
    state_next = state;
    grant      = '0;
    case (state)
      IDLE: begin
        if (!clear && any_pend) begin
          grant[sel] = 1'b1;
          state_next = ADD;
        end
      end
      ADD:     if (idx == IDX_W'(DIGITS - 1)) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  bcd_digit_add u_digit_add (
    .a    (work[idx]),
    .b    (addend[idx]),
    .cin  (carry),
    .sum  (dsum),
    .cout (dcout)
  );

  // Digit-serial datapath; score only moves in COMMIT so no partial sum is ever visible
  always_ff @(posedge Clk) begin
    if (Reset) begin
      score  <= '0;
      work   <= '0;
      addend <= '0;
      carry  <= 1'b0;
      idx    <= '0;
    end else if (clear) begin
      score <= '0;
      carry <= 1'b0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_pend) begin
            work      <= score;
            addend    <= '0;
            addend[0] <= pts_lo;
            addend[1] <= pts_hi;
            carry     <= 1'b0;
            idx       <= '0;
          end
        end
        ADD: begin
          work[idx] <= dsum;
          carry     <= dcout;
          idx       <= idx + IDX_W'(1);
        end
        COMMIT: score <= carry ? NINES[4*DIGITS-1:0] : work;
        default: ;
      endcase
    end
  end

  // High score is only taken once all awards have drained and nothing new is arriving
  assign hs_serve = hs_req && (state == IDLE) && !any_pend && !(|event_pulse) && !clear;

  // Sticky high-score request; game_over together with clear uses the pre-clear score
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hs_req <= 1'b0;
      high   <= '0;
    end else begin
      if (hs_serve || (clear && game_over)) high <= (score > high) ? score : high;
      if (clear)          hs_req <= 1'b0;
      else if (game_over) hs_req <= 1'b1;
      else if (hs_serve)  hs_req <= 1'b0;
    end
  end

  // Registered status flags, derived from next-cycle state so they line up with it
  always_ff @(posedge Clk) begin
    if (Reset) begin
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      busy_q    <= (state_next != IDLE) || (|cnt_next);
      dropped_q <= |drop_vec;
    end
  end

  assign score_bcd      = score;
  assign high_score_bcd = high;
  assign busy           = busy_q;
  assign dropped        = dropped_q;

endmodule
